// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared encodings, FSM state type and size/crossing helpers for
//            the data-memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // funct3 load/store width encodings
  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LD2  = 2'd1,
    ST2  = 2'd2
  } state_t;

  // Access size in bytes; unknown encodings fall back to a full word.
  function automatic logic [2:0] size_of(input logic [2:0] mode);
    case (mode)
      MODE_B, MODE_BU: size_of = 3'd1;
      MODE_H, MODE_HU: size_of = 3'd2;
      default:         size_of = 3'd4;
    endcase
  endfunction

  // True when the access spills into the next word.
  function automatic logic crosses(input logic [1:0] off, input logic [2:0] size);
    crosses = ({2'b00, off} + {1'b0, size}) > 4'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Purpose  : Byte-enable and lane-shifted write data for the first or second
//            word of an access. The access is viewed as an 8-lane window
//            spanning word k and word k+1; part selects which half is used.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_align #(
  parameter int D_WIDTH = 32
) (
  input  logic [1:0]         off,
  input  logic [2:0]         size,
  input  logic               part,
  input  logic [D_WIDTH-1:0] wdata,
  output logic [3:0]         be,
  output logic [D_WIDTH-1:0] data
);

  logic [7:0]           mask8;
  logic [2*D_WIDTH-1:0] wide;

  // Place the access in the two-word window, then pick the requested half.
  always_comb begin
    mask8 = (8'd1 << size) - 8'd1;
    mask8 = mask8 << off;
    wide  = {{D_WIDTH{1'b0}}, wdata} << {off, 3'b000};
    if (part) begin
      be   = mask8[7:4];
      data = wide[2*D_WIDTH-1:D_WIDTH];
    end else begin
      be   = mask8[3:0];
      data = wide[D_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Purpose  : Load/store controller around a word-organised RAM with byte-lane
//            writes. Word-crossing accesses take a second RAM cycle (LD2/ST2)
//            during which new requests are held off.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
  parameter int D_WIDTH = 32,
  parameter int ADDR_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [2:0]         req_mode,
  input  logic [D_WIDTH-1:0] req_wdata,
  output logic               rsp_valid,
  output logic [D_WIDTH-1:0] rsp_ramout,
  output logic [1:0]         rsp_sel,
  output logic [2:0]         rsp_mode
);
  import dmem_pkg::*;

  logic [D_WIDTH-1:0] mem [2**ADDR_W];

  state_t             state_q, state_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [D_WIDTH-1:0] rsp_ramout_q, rsp_ramout_d;
  logic [1:0]         rsp_sel_q, rsp_sel_d;
  logic [2:0]         rsp_mode_q, rsp_mode_d;
  logic [1:0]         off_q, off_d;
  logic [2:0]         size_q, size_d;
  logic [2:0]         mode_q, mode_d;
  logic [ADDR_W-1:0]  k1_q, k1_d;
  logic [D_WIDTH-1:0] wdata_q, wdata_d;
  logic [D_WIDTH-1:0] lo_q, lo_d;

  logic [1:0]         w_off;
  logic [ADDR_W-1:0]  w_k;
  logic [2:0]         w_size;
  logic               w_cross;
  logic               w_accept;
  logic               w_part;
  logic [1:0]         w_al_off;
  logic [2:0]         w_al_size;
  logic [D_WIDTH-1:0] w_al_wdata;
  logic [3:0]         w_al_be;
  logic [D_WIDTH-1:0] w_al_data;
  logic               w_wr_en;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [D_WIDTH-1:0] w_rd_word;
  logic [D_WIDTH-1:0] w_bytemask;
  logic [2:0]         w_n1;
  logic               w_addr_unused;

  assign w_addr_unused = ^req_addr[31:ADDR_W+2];

  assign req_ready  = (state_q == IDLE) && !rst;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_ramout = rsp_ramout_q;
  assign rsp_sel    = rsp_sel_q;
  assign rsp_mode   = rsp_mode_q;

  // Request decode, lane-align input muxing and RAM port addressing.
  always_comb begin
    w_off      = req_addr[1:0];
    w_k        = req_addr[ADDR_W+1:2];
    w_size     = size_of(req_mode);
    w_cross    = crosses(w_off, w_size);
    w_accept   = req_valid && req_ready;
    w_part     = (state_q != IDLE);
    w_al_off   = w_part ? off_q   : w_off;
    w_al_size  = w_part ? size_q  : w_size;
    w_al_wdata = w_part ? wdata_q : req_wdata;
    w_wr_en    = (w_accept && req_we) || (state_q == ST2);
    w_wr_addr  = (state_q == ST2) ? k1_q : w_k;
    w_rd_addr  = (state_q == LD2) ? k1_q : w_k;
    w_rd_word  = mem[w_rd_addr];
    w_n1       = 3'd4 - {1'b0, off_q};
    w_bytemask = '0;
    for (int i = 0; i < 4; i++) begin
      w_bytemask[8*i +: 8] = {8{w_al_be[i]}};
    end
  end

  dmem_lane_align #(
    .D_WIDTH (D_WIDTH)
  ) u_lane_align (
    .off   (w_al_off),
    .size  (w_al_size),
    .part  (w_part),
    .wdata (w_al_wdata),
    .be    (w_al_be),
    .data  (w_al_data)
  );

  // Next-state, response and split-access bookkeeping.
  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = 1'b0;
    rsp_ramout_d = rsp_ramout_q;
    rsp_sel_d    = rsp_sel_q;
    rsp_mode_d   = rsp_mode_q;
    off_d        = off_q;
    size_d       = size_q;
    mode_d       = mode_q;
    k1_d         = k1_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          off_d   = w_off;
          size_d  = w_size;
          mode_d  = req_mode;
          k1_d    = w_k + ADDR_W'(1);
          wdata_d = req_wdata;
          if (req_we) begin
            if (w_cross) state_d = ST2;
          end else if (w_cross) begin
            // Keep bytes off..3 of word k, packed down to bit 0.
            lo_d    = w_rd_word >> {w_off, 3'b000};
            state_d = LD2;
          end else begin
            rsp_valid_d  = 1'b1;
            rsp_ramout_d = w_rd_word;
            rsp_sel_d    = w_off;
            rsp_mode_d   = req_mode;
          end
        end
      end
      LD2: begin
        // Second-half byte enables double as the mask of bytes taken from k+1.
        rsp_valid_d  = 1'b1;
        rsp_ramout_d = lo_q | ((w_rd_word & w_bytemask) << {w_n1, 3'b000});
        rsp_sel_d    = 2'b00;
        rsp_mode_d   = mode_q;
        state_d      = IDLE;
      end
      ST2: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and response registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_ramout_q <= '0;
      rsp_sel_q    <= '0;
      rsp_mode_q   <= '0;
      off_q        <= '0;
      size_q       <= '0;
      mode_q       <= '0;
      k1_q         <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_ramout_q <= rsp_ramout_d;
      rsp_sel_q    <= rsp_sel_d;
      rsp_mode_q   <= rsp_mode_d;
      off_q        <= off_d;
      size_q       <= size_d;
      mode_q       <= mode_d;
      k1_q         <= k1_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
    end
  end

  // RAM byte-lane write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_al_be[i]) mem[w_wr_addr][8*i +: 8] <= w_al_data[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Purpose  : Directed self-checking bench for dmem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

  localparam int D_WIDTH = 32;
  localparam int ADDR_W  = 10;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic               req_we = 1'b0;
  logic [31:0]        req_addr = '0;
  logic [2:0]         req_mode = '0;
  logic [D_WIDTH-1:0] req_wdata = '0;
  logic               rsp_valid;
  logic [D_WIDTH-1:0] rsp_ramout;
  logic [1:0]         rsp_sel;
  logic [2:0]         rsp_mode;

  int n_checks = 0;
  int n_errors = 0;

  dmem_ctrl #(
    .D_WIDTH (D_WIDTH),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_mode   (req_mode),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ramout (rsp_ramout),
    .rsp_sel    (rsp_sel),
    .rsp_mode   (rsp_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request and return #1 after the edge that accepts it.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [2:0] mode, input logic [31:0] wdata);
    int waited;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_mode  = mode;
    req_wdata = wdata;
    waited    = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] data,
                           input logic [1:0] sel, input logic [2:0] mode);
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_data"}, rsp_ramout, data);
    check({tag, "_sel"}, {30'd0, rsp_sel}, {30'd0, sel});
    check({tag, "_mode"}, {29'd0, rsp_mode}, {29'd0, mode});
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_data", rsp_ramout, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // 1: aligned word load
    issue(1'b1, 32'h0, 3'b010, 32'h44332211);
    check("st_no_rsp", {31'd0, rsp_valid}, 32'd0);
    issue(1'b0, 32'h0, 3'b010, 32'h0);
    check_rsp("lw0", 32'h44332211, 2'd0, 3'b010);

    // 2: byte store then byte load at offset 1
    issue(1'b1, 32'h4, 3'b010, 32'h0);
    issue(1'b1, 32'h5, 3'b000, 32'h000000AB);
    issue(1'b0, 32'h5, 3'b000, 32'h0);
    check_rsp("lb5", 32'h0000AB00, 2'd1, 3'b000);
    issue(1'b0, 32'h4, 3'b010, 32'h0);
    check_rsp("lw4_after_sb", 32'h0000AB00, 2'd0, 3'b010);

    // 3: crossing LHU at offset 3
    issue(1'b1, 32'h4, 3'b010, 32'h88776655);
    issue(1'b0, 32'h3, 3'b101, 32'h0);
    check("lhu3_ready_n1", {31'd0, req_ready}, 32'd0);
    check("lhu3_valid_n1", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    check_rsp("lhu3", 32'h00005544, 2'd0, 3'b101);
    @(posedge clk);
    #1;
    check("lhu3_pulse", {31'd0, rsp_valid}, 32'd0);

    // 4: crossing SW at offset 2
    issue(1'b1, 32'h4, 3'b010, 32'h0);
    issue(1'b1, 32'h8, 3'b010, 32'h0);
    issue(1'b1, 32'h6, 3'b010, 32'hDDCCBBAA);
    check("sw6_ready_n1", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("sw6_ready_n2", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 32'h4, 3'b010, 32'h0);
    check_rsp("sw6_word1", 32'hBBAA0000, 2'd0, 3'b010);
    issue(1'b0, 32'h8, 3'b010, 32'h0);
    check_rsp("sw6_word2", 32'h0000DDCC, 2'd0, 3'b010);

    // crossing LW at offset 1
    issue(1'b0, 32'h5, 3'b010, 32'h0);
    @(posedge clk);
    #1;
    check_rsp("lw5_cross", 32'hCCBBAA00, 2'd0, 3'b010);

    // 5: read-after-write and index wrap
    issue(1'b1, 32'h8, 3'b010, 32'h12345678);
    issue(1'b0, 32'h8, 3'b010, 32'h0);
    check_rsp("raw8", 32'h12345678, 2'd0, 3'b010);
    issue(1'b1, 32'h0000_0FFC, 3'b010, 32'hBBAA0000);
    issue(1'b1, 32'h0, 3'b010, 32'h0000DDCC);
    issue(1'b0, 32'h0000_0FFE, 3'b010, 32'h0);
    @(posedge clk);
    #1;
    check_rsp("wrap", 32'hDDCCBBAA, 2'd0, 3'b010);
    issue(1'b0, 32'h0000_1000, 3'b010, 32'h0);
    check_rsp("alias", 32'h0000DDCC, 2'd0, 3'b010);

    // 6: reset during LD2 drops the response
    issue(1'b1, 32'h0, 3'b010, 32'h44332211);
    issue(1'b1, 32'h4, 3'b010, 32'h88776655);
    issue(1'b0, 32'h3, 3'b101, 32'h0);
    rst = 1'b1;
    #1;
    check("ld2rst_ready", {31'd0, req_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("ld2rst_valid", {31'd0, rsp_valid}, 32'd0);
      check("ld2rst_data", rsp_ramout, 32'd0);
      check("ld2rst_selmode", {27'd0, rsp_sel, rsp_mode}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ld2rst_ready_after", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 32'h0, 3'b010, 32'h0);
    check_rsp("ld2rst_lw", 32'h44332211, 2'd0, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
